tlul_socket_1n: RTL and testbench
=================================

Name: tlul_socket_1n

Overview:
- Single-host to N-device TL-UL socket, the fan-out counterpart of the M:1 host-merging socket.
- Steers each A-channel request to one device port using an externally decoded `dev_select_i`.
- Tracks outstanding requests so that D-channel responses return in order from the correct device.
- An internal error responder answers any request whose select is out of range (unmapped address).

Parameters:
- N, 4: number of device ports; legal range 1..15.
- MaxOutstanding, 8: maximum outstanding requests in flight; legal range 1..255.
- DevSelW, $clog2(N+1): width of `dev_select_i`. Value N selects the error responder.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- tl_h_i  input  tlul_pkg::tl_h2d_t  host request channel.
- tl_h_o  output  tlul_pkg::tl_d2h_t  host response channel.
- dev_select_i  input  DevSelW  target device for `tl_h_i`; must be stable while `tl_h_i.a_valid` is high.
- tl_d_o  output  tlul_pkg::tl_h2d_t [N]  device request channels.
- tl_d_i  input  tlul_pkg::tl_d2h_t [N]  device response channels.

Behaviour:
- State:
  - `num_req_q`: outstanding count, width $clog2(MaxOutstanding+1).
  - `dev_select_q`: DevSelW, the target of the current outstanding group.
- Reset: `num_req_q`=0, `dev_select_q`=0, error responder IDLE. All `tl_d_o[i].a_valid`=0 and `tl_h_o.d_valid`=0; `tl_h_o.a_ready` may be high only as given by the stall rule below.
- Stall condition: `hold = (num_req_q != 0 && dev_select_i != dev_select_q) || num_req_q == MaxOutstanding`.
- Request path (combinational, zero latency):
  - `tl_d_o[i]` carries all `tl_h_i` A fields.
  - `tl_d_o[i].a_valid = tl_h_i.a_valid & !hold & (dev_select_i == i)`.
  - `tl_h_o.a_ready = !hold & ready of the selected target`, where the error responder is the target when select is N.
  - Select values > N behave as N.
- Accept: `acc = tl_h_i.a_valid & tl_h_o.a_ready`. On `acc`, `dev_select_q <= dev_select_i`.
- Response path:
  - `tl_h_o` D fields and `d_valid` are muxed from `dev_select_q` (device or error responder).
  - `tl_d_o[i].d_ready = tl_h_i.d_ready & (dev_select_q == i)`.
  - Non-selected devices see `d_ready`=0.
- Completion: `cmp = tl_h_o.d_valid & tl_h_i.d_ready`.
- Counter update:
  - `acc` & !`cmp`: +1.
  - `cmp` & !`acc`: -1.
  - Both in the same cycle: unchanged.
  - `cmp` with `num_req_q`==0 is a protocol error; assert, and the counter must not underflow.
- Switching targets: a request to a different device stalls until `num_req_q` returns to 0. A same-cycle `cmp` taking the count to 0 does not release the stall until the next cycle.
- Error responder FSM (IDLE → RESP):
  - IDLE: `a_ready`=1. On accept, latch `a_source`, `a_size`, and `a_opcode`, then go to RESP.
  - RESP: `d_valid`=1, `a_ready`=0, `d_error`=1, `d_data`=all-ones, `d_source`/`d_size` echoed.
  - `d_opcode` is AccessAckData for Get and AccessAck otherwise.
  - Hold RESP until `d_ready`, then return to IDLE. Latency is accept + 1 cycle.
- Reset mid-transaction: all state is cleared immediately. Responses from devices arriving after reset are dropped (`d_ready`=0 while the count is 0 is not required; they are routed to `dev_select_q`=0).
- Assertions:
  - `dev_select_i` stable while `a_valid` is high and not accepted.
  - `num_req_q <= MaxOutstanding`.

Decomposition:
- Reuse `tlul_pkg` types and opcodes (`Get`, `AccessAck`, `AccessAckData`).
- No new package constants.
- One sub-module: `tlul_err_resp`, the error-responder FSM with a single h2d/d2h port pair.

Test Plan:
- Three back-to-back Get requests to dev 1, with dev 1 responding after 2 cycles each → `a_valid` seen only on `tl_d_o[1]`; `num_req_q` goes 1, 2, 3 then back to 0; responses reach the host in order.
- Outstanding=1 at dev 0, then a new request to dev 2 → `tl_h_o.a_ready`=0 until dev 0 responds. `tl_d_o[2].a_valid` rises the cycle after the count hits 0.
- MaxOutstanding=8: 8 requests to dev 3 with no responses → the 9th request stalls with `a_ready`=0; the 1st response releases it.
- `dev_select_i`=4 (N), Get with `a_source`=0x5, `a_size`=2 → next cycle `d_valid`=1, `d_error`=1, `d_opcode`=AccessAckData, `d_data`=0xFFFFFFFF, `d_source`=0x5.
- Accept and completion in the same cycle at count 2 → count stays 2.
- Assert `rst_i` with 3 outstanding → next edge: count 0, all `a_valid`/`d_valid` outputs 0, error FSM IDLE.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL channel types and opcodes shared by the socket and its error responder.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    // Valid/ready: a beat moves on a channel in a cycle where both valid and
    // ready are high; a raised valid and its payload hold until that happens.
    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_err_resp.sv
// Error responder for unmapped requests: accepts one request, answers it with
// d_error set and all-ones data on the following cycle.
module tlul_err_resp
    import tlul_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i,
    output tl_d2h_t tl_h_o,
    output logic    state_o
);

    typedef enum logic {
        ErrIdle = 1'b0,
        ErrResp = 1'b1
    } err_state_e;

    err_state_e        state_q, state_d;
    logic [TL_AIW-1:0] source_q;
    logic [TL_SZW-1:0] size_q;
    tl_a_op_e          opcode_q;
    logic              acc;

    assign acc     = tl_h_i.a_valid && (state_q == ErrIdle);
    assign state_o = (state_q == ErrResp);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ErrIdle;
            source_q <= '0;
            size_q   <= '0;
            opcode_q <= PutFullData;
        end else begin
            state_q <= state_d;
            if (acc) begin
                source_q <= tl_h_i.a_source;
                size_q   <= tl_h_i.a_size;
                opcode_q <= tl_h_i.a_opcode;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        tl_h_o          = '0;
        tl_h_o.d_opcode = (opcode_q == Get) ? AccessAckData : AccessAck;
        tl_h_o.d_size   = size_q;
        tl_h_o.d_source = source_q;
        tl_h_o.d_data   = '1;
        tl_h_o.d_error  = 1'b1;
        case (state_q)
            ErrIdle: begin
                tl_h_o.a_ready = 1'b1;
                if (tl_h_i.a_valid) begin
                    state_d = ErrResp;
                end
            end
            ErrResp: begin
                tl_h_o.d_valid = 1'b1;
                if (tl_h_i.d_ready) begin
                    state_d = ErrIdle;
                end
            end
            default: state_d = ErrIdle;
        endcase
    end

    logic unused_a_fields;
    assign unused_a_fields = ^{tl_h_i.a_param, tl_h_i.a_address, tl_h_i.a_mask, tl_h_i.a_data};

endmodule

// File: rtl/tlul_socket_1n.sv
// 1:N TL-UL socket: steers host requests to a decoded device (or the error
// responder) and returns responses in order from the current target group.
module tlul_socket_1n
    import tlul_pkg::*;
#(
    parameter int unsigned N              = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned DevSelW        = $clog2(N + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tl_h2d_t            tl_h_i,
    output tl_d2h_t            tl_h_o,
    input  logic [DevSelW-1:0] dev_select_i,
    output tl_h2d_t            tl_d_o [N],
    input  tl_d2h_t            tl_d_i [N]
);

    localparam int unsigned      CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [DevSelW-1:0] ErrSel = DevSelW'(N);
    localparam logic [CntW-1:0]  MaxCnt = CntW'(MaxOutstanding);

    logic [CntW-1:0]    num_req_q, num_req_d;
    logic [DevSelW-1:0] dev_select_q, dev_select_d;
    logic [DevSelW-1:0] sel_a;
    logic               hold;
    logic               tgt_ready;
    logic               acc, cmp;
    tl_h2d_t            err_h2d;
    tl_d2h_t            err_d2h;
    tl_d2h_t            rsp;
    logic               err_busy;

    // Any out-of-range select is folded onto the error responder.
    assign sel_a = (dev_select_i >= ErrSel) ? ErrSel : dev_select_i;

    // A new target may only be taken once the previous group has fully drained.
    assign hold = ((num_req_q != '0) && (sel_a != dev_select_q)) || (num_req_q == MaxCnt);

    always_comb begin
        tgt_ready = err_d2h.a_ready;
        rsp       = err_d2h;
        err_h2d          = tl_h_i;
        err_h2d.a_valid  = tl_h_i.a_valid && !hold && (sel_a == ErrSel);
        err_h2d.d_ready  = tl_h_i.d_ready && (dev_select_q == ErrSel);
        for (int i = 0; i < int'(N); i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = tl_h_i.a_valid && !hold && (sel_a == DevSelW'(i));
            tl_d_o[i].d_ready = tl_h_i.d_ready && (dev_select_q == DevSelW'(i));
            if (sel_a == DevSelW'(i)) begin
                tgt_ready = tl_d_i[i].a_ready;
            end
            if (dev_select_q == DevSelW'(i)) begin
                rsp = tl_d_i[i];
            end
        end
        tl_h_o         = rsp;
        tl_h_o.a_ready = !hold && tgt_ready;
    end

    assign acc = tl_h_i.a_valid && tl_h_o.a_ready;
    assign cmp = tl_h_o.d_valid && tl_h_i.d_ready;

    always_comb begin
        num_req_d    = num_req_q;
        dev_select_d = dev_select_q;
        if (acc) begin
            dev_select_d = sel_a;
        end
        if (acc && !cmp) begin
            num_req_d = num_req_q + CntW'(1);
        end else if (cmp && !acc && (num_req_q != '0)) begin
            num_req_d = num_req_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            num_req_q    <= '0;
            dev_select_q <= '0;
        end else begin
            num_req_q    <= num_req_d;
            dev_select_q <= dev_select_d;
        end
    end

    tlul_err_resp u_err_resp (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .tl_h_i  (err_h2d),
        .tl_h_o  (err_d2h),
        .state_o (err_busy)
    );

    a_sel_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (tl_h_i.a_valid && !tl_h_o.a_ready) |=> (!tl_h_i.a_valid || $stable(dev_select_i)));

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        cmp |-> (num_req_q != '0));

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        num_req_q <= MaxCnt);

    a_err_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        err_busy |-> !err_d2h.a_ready);

endmodule

// File: tb/tb_tlul_socket_1n.sv
// Randomized bench for tlul_socket_1n: device stubs, an in-order expected
// response queue and a count/target model of the socket's stall rules.
module tb_tlul_socket_1n;
    import tlul_pkg::*;

    localparam int N      = 4;
    localparam int MaxOut = 8;
    localparam int SelW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    tl_h2d_t          h_i;
    tl_d2h_t          h_o;
    logic [SelW-1:0]  sel_i;
    tl_h2d_t          d_o [N];
    tl_d2h_t          d_i [N];

    always #5 clk = ~clk;

    tlul_socket_1n #(.N(N), .MaxOutstanding(MaxOut)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tl_h_i       (h_i),
        .tl_h_o       (h_o),
        .dev_select_i (sel_i),
        .tl_d_o       (d_o),
        .tl_d_i       (d_i)
    );

    typedef struct {
        int          tgt;
        tl_a_op_e    op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] addr;
    } req_t;

    req_t exp_q[$];
    int   cnt_m, sel_m, dly;
    bit   dev_stall, last_acc;
    bit   hit_max, hit_switch, hit_both, hit_err;
    int   checks, failures;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dev_data(input req_t r);
        return r.addr ^ {16'hA5A5, 8'(r.tgt), r.src};
    endfunction

    // mode 0: random, 1: stream to dev 3, 2: error-heavy, 3: no new requests
    task automatic drive(input int mode, input bit do_rst);
        logic [63:0] rnd;
        req_t        r;
        rst = do_rst;
        if (do_rst) begin
            h_i.a_valid = 1'b0;
            exp_q.delete();
            cnt_m = 0;
            sel_m = 0;
            dly   = 0;
        end else if (!(h_i.a_valid && !last_acc)) begin
            case (mode)
                1: begin h_i.a_valid = 1'b1; sel_i = 3'd3; end
                2: begin
                    h_i.a_valid = ($urandom_range(0, 3) != 0);
                    sel_i = ($urandom_range(0, 1) != 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 7));
                end
                3: h_i.a_valid = 1'b0;
                default: begin
                    h_i.a_valid = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 9) < 4) sel_i = 3'($urandom_range(0, 7));
                end
            endcase
            case ($urandom_range(0, 3))
                0: h_i.a_opcode = PutFullData;
                1: h_i.a_opcode = PutPartialData;
                default: h_i.a_opcode = Get;
            endcase
            h_i.a_param   = 3'd0;
            h_i.a_size    = 2'($urandom_range(0, 2));
            h_i.a_source  = 8'($urandom);
            h_i.a_address = $urandom;
            h_i.a_mask    = 4'($urandom);
            h_i.a_data    = $urandom;
        end
        h_i.d_ready = ($urandom_range(0, 4) != 0);
        if (dly > 0) dly--;
        for (int i = 0; i < N; i++) begin
            rnd = {$urandom, $urandom};
            d_i[i] = rnd[$bits(tl_d2h_t)-1:0];
            d_i[i].d_valid = 1'b0;
            d_i[i].a_ready = ($urandom_range(0, 3) != 0);
        end
        if (!do_rst && exp_q.size() > 0 && exp_q[0].tgt < N && dly == 0 && !dev_stall) begin
            r = exp_q[0];
            d_i[r.tgt].d_valid  = 1'b1;
            d_i[r.tgt].d_opcode = (r.op == Get) ? AccessAckData : AccessAck;
            d_i[r.tgt].d_param  = 3'd0;
            d_i[r.tgt].d_size   = r.size;
            d_i[r.tgt].d_source = r.src;
            d_i[r.tgt].d_sink   = 1'b0;
            d_i[r.tgt].d_data   = dev_data(r);
            d_i[r.tgt].d_error  = 1'b0;
        end
    endtask

    task automatic evaluate();
        int          se;
        bit          hold_m, tr, exp_ar, exp_dv, acc, cmp;
        req_t        r;
        logic [31:0] ed;
        bit          ee;
        tl_d_op_e    eo;
        se     = (int'(sel_i) > N) ? N : int'(sel_i);
        hold_m = (cnt_m > 0 && se != sel_m) || cnt_m == MaxOut;
        tr     = (se < N) ? d_i[se].a_ready : !(cnt_m > 0 && sel_m == N);
        exp_ar = !hold_m && tr;
        exp_dv = (cnt_m > 0) && ((sel_m == N) ? 1'b1 : d_i[sel_m].d_valid);
        check_eq("num_req", 64'(dut.num_req_q), 64'(cnt_m));
        check_eq("a_ready", 64'(h_o.a_ready), 64'(exp_ar));
        check_eq("d_valid", 64'(h_o.d_valid), 64'(exp_dv));
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("dev%0d_a_valid", i), 64'(d_o[i].a_valid),
                     64'(h_i.a_valid && !hold_m && se == i));
            check_eq($sformatf("dev%0d_d_ready", i), 64'(d_o[i].d_ready),
                     64'(h_i.d_ready && sel_m == i));
        end
        if (h_i.a_valid && se < N && !hold_m) begin
            check_eq("fwd_a", 64'({d_o[se].a_address, d_o[se].a_source, d_o[se].a_size, d_o[se].a_opcode}),
                     64'({h_i.a_address, h_i.a_source, h_i.a_size, h_i.a_opcode}));
        end
        if (h_i.a_valid && cnt_m > 0 && se != sel_m) hit_switch = 1'b1;
        acc = h_i.a_valid && exp_ar;
        cmp = exp_dv && h_i.d_ready;
        if (acc && cmp) hit_both = 1'b1;
        if (cmp) begin
            r  = exp_q.pop_front();
            ee = (r.tgt == N);
            ed = ee ? 32'hFFFF_FFFF : dev_data(r);
            eo = (r.op == Get) ? AccessAckData : AccessAck;
            if (ee) hit_err = 1'b1;
            check_eq("rsp", 64'({h_o.d_data, h_o.d_error, h_o.d_opcode, h_o.d_source, h_o.d_size}),
                     64'({ed, ee, eo, r.src, r.size}));
            dly = $urandom_range(1, 3);
        end
        if (acc) begin
            r.tgt  = se;
            r.op   = h_i.a_opcode;
            r.size = h_i.a_size;
            r.src  = h_i.a_source;
            r.addr = h_i.a_address;
            if (exp_q.size() == 0) dly = $urandom_range(1, 3);
            exp_q.push_back(r);
            sel_m = se;
        end
        cnt_m    = cnt_m + int'(acc) - int'(cmp);
        last_acc = acc;
        if (cnt_m == MaxOut) hit_max = 1'b1;
    endtask

    task automatic cycle(input int mode, input bit do_rst);
        drive(mode, do_rst);
        @(negedge clk);
        evaluate();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        checks = 0; failures = 0;
        cnt_m = 0; sel_m = 0; dly = 0;
        dev_stall = 1'b0; last_acc = 1'b0;
        hit_max = 1'b0; hit_switch = 1'b0; hit_both = 1'b0; hit_err = 1'b0;
        rst = 1'b1;
        h_i = '0;
        sel_i = '0;
        for (int i = 0; i < N; i++) d_i[i] = '0;
        @(posedge clk);
        #1;
        cycle(0, 1'b1);
        cycle(0, 1'b1);
        repeat (400) cycle(0, 1'b0);
        repeat (30) cycle(3, 1'b0);
        dev_stall = 1'b1;
        repeat (30) cycle(1, 1'b0);
        dev_stall = 1'b0;
        repeat (30) cycle(1, 1'b0);
        repeat (300) cycle(2, 1'b0);
        guard = 0;
        while (cnt_m < 2 && guard < 200) begin
            cycle(0, 1'b0);
            guard++;
        end
        check_eq("pre_reset_outstanding", 64'(cnt_m >= 2), 64'd1);
        cycle(0, 1'b1);
        repeat (300) cycle(0, 1'b0);
        repeat (40) cycle(3, 1'b0);
        check_eq("drained", 64'(exp_q.size()), 64'd0);
        check_eq("hit_max", 64'(hit_max), 64'd1);
        check_eq("hit_switch", 64'(hit_switch), 64'd1);
        check_eq("hit_both", 64'(hit_both), 64'd1);
        check_eq("hit_err", 64'(hit_err), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
